// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU issue/capture sequencer.
package alu_seq_pkg;

    localparam int unsigned W_DEF     = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALUop encodings as the downstream ALU sees them; the sequencer only forwards them.
    localparam logic [1:0] ALUOP_0 = 2'b00;
    localparam logic [1:0] ALUOP_1 = 2'b01;
    localparam logic [1:0] ALUOP_2 = 2'b10;
    localparam logic [1:0] ALUOP_3 = 2'b11;

endpackage

// File: rtl/alu_seq_if.sv
// Command, ALU-side and response signals of the sequencer, bundled with
// a slave view (the sequencer) and a master view (its environment).
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_aluop;
    logic             cmd_l;
    logic [W-1:0]     cmd_a;
    logic [W-1:0]     cmd_b;
    logic             cmd_src_acc;

    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [1:0]       alu_op;
    logic             alu_l;
    logic [W-1:0]     alu_r;
    logic             alu_zero;
    logic             alu_carry;
    logic             alu_sign;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_r;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_sign;

    logic [CNT_W-1:0] ops_done;

    modport slave (
        input  cmd_valid, cmd_aluop, cmd_l, cmd_a, cmd_b, cmd_src_acc,
        input  alu_r, alu_zero, alu_carry, alu_sign,
        input  rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, alu_l,
        output rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_sign, ops_done
    );

    modport master (
        output cmd_valid, cmd_aluop, cmd_l, cmd_a, cmd_b, cmd_src_acc,
        output alu_r, alu_zero, alu_carry, alu_sign,
        output rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, alu_l,
        input  rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_sign, ops_done
    );

endinterface

// File: rtl/alu_seq.sv
// Issue/capture sequencer in front of the combinational ALU: IDLE -> EXEC -> RESP.
// Optional accumulator operand source enabled by macro ALU_SEQ_ACC_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W     = W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    logic             load_cmd;
    logic             capture;
    logic             retire;

    logic             cmd_ready_q;
    logic [W-1:0]     operand_a;
    logic [W-1:0]     alu_a_q;
    logic [W-1:0]     alu_b_q;
    logic [1:0]       alu_op_q;
    logic             alu_l_q;
    logic             rsp_valid_q;
    logic [W-1:0]     rsp_r_q;
    logic             rsp_zero_q;
    logic             rsp_carry_q;
    logic             rsp_sign_q;
    logic [CNT_W-1:0] ops_done_q;

`ifdef ALU_SEQ_ACC_EN
    logic [W-1:0] acc_q;

    // Accumulator tracks the most recently captured result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (capture) begin
            acc_q <= bus.alu_r;
        end
    end

    assign operand_a = bus.cmd_src_acc ? acc_q : bus.cmd_a;
`else
    logic unused_src_acc;
    assign unused_src_acc = bus.cmd_src_acc;
    assign operand_a      = bus.cmd_a;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_cmd = 1'b0;
        capture  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    load_cmd = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand issue, result capture and completion count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_l_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_sign_q  <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            if (load_cmd) begin
                alu_a_q  <= operand_a;
                alu_b_q  <= bus.cmd_b;
                alu_op_q <= bus.cmd_aluop;
                alu_l_q  <= bus.cmd_l;
            end
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_r_q     <= bus.alu_r;
                rsp_zero_q  <= bus.alu_zero;
                rsp_carry_q <= bus.alu_carry;
                rsp_sign_q  <= bus.alu_sign;
            end
            if (retire) begin
                rsp_valid_q <= 1'b0;
                ops_done_q  <= ops_done_q + CNT_W'(1);
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_l     = alu_l_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_sign  = rsp_sign_q;
    assign bus.ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, reset corner, accumulator
// sequence (when ALU_SEQ_ACC_EN is defined) and 256 random back-to-back operations.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       s;
    } res_t;

    typedef struct {
        logic [1:0] op;
        logic       l;
        logic [3:0] a;
        logic [3:0] b;
        int         hold;
        logic [3:0] r;
        logic       z;
        logic       c;
        logic       s;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_ops;

    alu_seq_if #(.W(W), .CNT_W(CNT_W)) bus ();

    alu_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit ALU: L=1 logic ops, L=0 arithmetic with carry out.
    function automatic res_t alu_ref(input logic [1:0] op, input logic l,
                                     input logic [3:0] a, input logic [3:0] b);
        res_t       x;
        logic [4:0] t;
        if (l) begin
            case (op)
                2'b00:   t = {1'b0, a & b};
                2'b01:   t = {1'b0, a | b};
                2'b10:   t = {1'b0, a ^ b};
                default: t = {1'b0, ~a};
            endcase
        end else begin
            case (op)
                2'b00:   t = {1'b0, a} + {1'b0, b};
                2'b01:   t = {1'b0, a} + {1'b0, ~b} + 5'd1;
                2'b10:   t = {1'b0, a} + 5'd1;
                default: t = {1'b0, a} + 5'd15;
            endcase
        end
        x.r = t[3:0];
        x.c = t[4];
        x.z = (t[3:0] == 4'd0);
        x.s = t[3];
        return x;
    endfunction

    res_t stub;
    assign stub          = alu_ref(bus.alu_op, bus.alu_l, bus.alu_a, bus.alu_b);
    assign bus.alu_r     = stub.r;
    assign bus.alu_zero  = stub.z;
    assign bus.alu_carry = stub.c;
    assign bus.alu_sign  = stub.s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] op, input logic l, input logic [3:0] a,
                         input logic [3:0] b, input logic src, input logic [3:0] exp_a,
                         input int hold, input res_t exp);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("cmd_ready_before_issue", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_aluop   = op;
        bus.cmd_l       = l;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_src_acc = src;
        bus.rsp_ready   = (hold == 0);
        step();
        // A second command stays pending while this one is in flight.
        bus.cmd_valid = (hold > 0);
        bus.cmd_a     = ~a;
        bus.cmd_b     = ~b;
        check("issue_alu_a", 32'(bus.alu_a), 32'(exp_a));
        check("issue_alu_b", 32'(bus.alu_b), 32'(b));
        check("issue_alu_op", 32'({bus.alu_op, bus.alu_l}), 32'({op, l}));
        check("exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_result", 32'({bus.rsp_r, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign}), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_rsp", 32'({bus.rsp_valid, bus.rsp_r, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign}),
                  32'({1'b1, exp}));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("hold_alu_a", 32'(bus.alu_a), 32'(exp_a));
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        exp_ops++;
        check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("done_ops", 32'(bus.ops_done), 32'(CNT_W'(exp_ops)));
        check("done_rsp_kept", 32'(bus.rsp_r), 32'(exp.r));
    endtask

    initial begin
        vec_t tbl[8];
        res_t q[$];
        res_t got;
        int   pops;
        int   steps;

        checks  = 0;
        errors  = 0;
        exp_ops = 0;

        tbl[0] = '{2'b00, 1'b0, 4'h5, 4'h4, 0, 4'h9, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{2'b00, 1'b0, 4'h9, 4'h8, 5, 4'h1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{2'b00, 1'b0, 4'h8, 4'h8, 0, 4'h0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{2'b01, 1'b0, 4'h3, 4'h5, 2, 4'hE, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b00, 1'b1, 4'hC, 4'hA, 0, 4'h8, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{2'b01, 1'b1, 4'hC, 4'h3, 1, 4'hF, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'b10, 1'b1, 4'hA, 4'hA, 0, 4'h0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{2'b11, 1'b0, 4'h0, 4'h6, 0, 4'hF, 1'b0, 1'b0, 1'b1};

        reset           = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_aluop   = 2'b00;
        bus.cmd_l       = 1'b0;
        bus.cmd_a       = 4'h0;
        bus.cmd_b       = 4'h0;
        bus.cmd_src_acc = 1'b0;
        bus.rsp_ready   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_ops_done", 32'(bus.ops_done), 32'd0);
        check("reset_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_l}), 32'd0);
        check("reset_rsp", 32'({bus.rsp_r, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].op, tbl[i].l, tbl[i].a, tbl[i].b, 1'b0, tbl[i].a, tbl[i].hold,
                  '{tbl[i].r, tbl[i].z, tbl[i].c, tbl[i].s});
        end

        // Reset while a response is pending, with a command offered in the reset cycle.
        bus.cmd_valid = 1'b1;
        bus.cmd_aluop = 2'b00;
        bus.cmd_l     = 1'b0;
        bus.cmd_a     = 4'h7;
        bus.cmd_b     = 4'h1;
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("pre_reset_in_resp", 32'(bus.rsp_valid), 32'd1);
        reset         = 1'b1;
        bus.cmd_valid = 1'b1;
        step();
        reset = 1'b0;
        check("rst_resp_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_resp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_resp_ops_done", 32'(bus.ops_done), 32'd0);
        check("rst_resp_alu_a", 32'(bus.alu_a), 32'd0);
        bus.cmd_valid = 1'b0;
        step();
        check("rst_cmd_not_taken", 32'({bus.cmd_ready, bus.alu_a}), 32'({1'b1, 4'h0}));
        exp_ops = 0;

`ifdef ALU_SEQ_ACC_EN
        do_op(2'b00, 1'b0, 4'h3, 4'h2, 1'b0, 4'h3, 0, '{4'h5, 1'b0, 1'b0, 1'b0});
        do_op(2'b00, 1'b0, 4'hF, 4'h1, 1'b1, 4'h5, 0, '{4'h6, 1'b0, 1'b0, 1'b0});
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_ops = 0;
`endif

        // Back-to-back random stream: throughput, results and counter wrap.
        pops          = 0;
        steps         = 0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        while (pops < 256 && steps < 2000) begin
            if (bus.cmd_ready === 1'b1) begin
                q.push_back(alu_ref(bus.cmd_aluop, bus.cmd_l, bus.cmd_a, bus.cmd_b));
            end
            step();
            steps++;
            bus.cmd_aluop = 2'($urandom_range(0, 3));
            bus.cmd_l     = 1'($urandom_range(0, 1));
            bus.cmd_a     = 4'($urandom_range(0, 15));
            bus.cmd_b     = 4'($urandom_range(0, 15));
`ifdef ALU_SEQ_ACC_EN
            bus.cmd_src_acc = 1'b0;
`else
            bus.cmd_src_acc = 1'($urandom_range(0, 1));
`endif
            if (bus.rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    got = '{bus.rsp_r, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign};
                    check("rand_rsp", 32'(got), 32'(q.pop_front()));
                end
                pops++;
                if (pops == 256) begin
                    check("rand_ops_before_wrap", 32'(bus.ops_done), 32'd255);
                    check("rand_throughput_cycles", 32'(steps), 32'd767);
                end
            end
        end
        check("rand_all_responses", 32'(pops), 32'd256);
        bus.cmd_valid = 1'b0;
        step();
        bus.rsp_ready = 1'b0;
        check("rand_ops_wrapped", 32'(bus.ops_done), 32'd0);
        check("rand_end_rsp_valid", 32'(bus.rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
